// File: rtl/cm_pkg.sv
// cm_pkg: lane, fault-code, state and indication encodings shared by conflict_monitor
package cm_pkg;
  localparam int LANE_SS_STRAIGHT = 0;
  localparam int LANE_SS_TURN     = 1;
  localparam int LANE_CS_STRAIGHT = 2;
  localparam int LANE_CS_TURN     = 3;
  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_INVALID  = 3'd2;
  localparam logic [2:0] FC_G2R      = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;
  localparam logic [2:0] FC_PED      = 3'd5;
  typedef enum logic [1:0] {STARTUP, MONITOR, FAULT} state_t;
  typedef enum logic [1:0] {IND_R, IND_Y, IND_G, IND_BAD} ind_t;
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/cm_lane_checker.sv
// cm_lane_checker: per-lane indication decode, history, yellow dwell and transition checks
module cm_lane_checker
  import cm_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic g,
  input  logic y,
  input  logic r,
  output logic active,
  output logic invalid,
  output logic g_to_r,
  output logic short_yellow
);
  localparam int YW = $clog2(MIN_YELLOW_CYCLES + 1);
  ind_t ind, hist_q, hist_d;
  logic [YW-1:0] dwell_q, dwell_d;
  always_comb begin
    ind = ({g, y, r} == 3'b100) ? IND_G : ({g, y, r} == 3'b010) ? IND_Y : ({g, y, r} == 3'b001) ? IND_R : IND_BAD;
    hist_d = ind;
    dwell_d = (ind != IND_Y) ? '0 : (dwell_q == YW'(MIN_YELLOW_CYCLES)) ? dwell_q : dwell_q + YW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= IND_R;
      dwell_q <= '0;
    end else begin
      hist_q <= hist_d;
      dwell_q <= dwell_d;
    end
  end
  assign active = g | y;
  assign invalid = ind == IND_BAD;
  assign g_to_r = (hist_q == IND_G) && (ind == IND_R);
  assign short_yellow = (hist_q == IND_Y) && (ind == IND_R) && (dwell_q < YW'(MIN_YELLOW_CYCLES));
endmodule

// File: rtl/conflict_monitor.sv
// conflict_monitor: latches the first unsafe lamp indication and forces all-red flash; CM_FAULT_LOG_EN adds fault_count
module conflict_monitor
  import cm_pkg::*;
#(
  parameter int CLK_HZ            = 1000,
  parameter int FILTER_CYCLES     = 50,
  parameter int MIN_YELLOW_CYCLES = 3000,
  parameter int STARTUP_CYCLES    = 2000,
  parameter int FLASH_HALF_CYCLES = CLK_HZ / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] green,
  input  logic [3:0] yellow,
  input  logic [3:0] red,
  input  logic [1:0] walk,
  input  logic [1:0] hand,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_lane,
  output logic       flash_enable,
`ifdef CM_FAULT_LOG_EN
  output logic       flash_phase,
  output logic [7:0] fault_count
`else
  output logic       flash_phase
`endif
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam int PW = $clog2(FLASH_HALF_CYCLES + 1);
  logic [3:0] act, bad, g2r, shy;
  logic [1:0] ped, lane, lane_q, lane_d;
  logic [2:0] code, code_q, code_d;
  logic conflict, level, mon, hit_lvl, hit, restart, phase_q, phase_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [SW-1:0] st_cnt_q, st_cnt_d;
  logic [PW-1:0] ph_cnt_q, ph_cnt_d;
  state_t state_q, state_d;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    cm_lane_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .g(green[i]),
      .y(yellow[i]),
      .r(red[i]),
      .active(act[i]),
      .invalid(bad[i]),
      .g_to_r(g2r[i]),
      .short_yellow(shy[i])
    );
  end
  always_comb begin
    ped[0] = walk[0] & (hand[0] | act[LANE_SS_TURN] | act[LANE_CS_STRAIGHT] | act[LANE_CS_TURN]);
    ped[1] = walk[1] & (hand[1] | act[LANE_SS_STRAIGHT] | act[LANE_SS_TURN] | act[LANE_CS_TURN]);
    conflict = |(act & (act - 4'd1));
    level = conflict | (|bad) | (|ped);
    mon = state_q == MONITOR;
    hit_lvl = mon & level & (filt_q >= FW'(FILTER_CYCLES - 1));
    code = (hit_lvl & conflict) ? FC_CONFLICT : (hit_lvl & (|bad)) ? FC_INVALID : (mon & (|g2r)) ? FC_G2R :
           (mon & (|shy)) ? FC_SHORT_Y : (hit_lvl & (|ped)) ? FC_PED : FC_NONE;
    lane = (code == FC_CONFLICT) ? low_idx(act) : (code == FC_INVALID) ? low_idx(bad) :
           (code == FC_G2R) ? low_idx(g2r) : (code == FC_SHORT_Y) ? low_idx(shy) : low_idx({2'b00, ped});
    hit = code != FC_NONE;
    filt_d = !(mon & level) ? '0 : (filt_q == FW'(FILTER_CYCLES)) ? filt_q : filt_q + FW'(1);
    state_d = (state_q == STARTUP) ? ((st_cnt_q == SW'(STARTUP_CYCLES - 1)) ? MONITOR : STARTUP) :
              (state_q == MONITOR) ? (hit ? FAULT : MONITOR) : (clear_fault ? STARTUP : FAULT);
    st_cnt_d = (state_q == STARTUP) ? st_cnt_q + SW'(1) : '0;
    restart = (state_d == MONITOR) | (state_d != state_q);
    ph_cnt_d = (restart | (ph_cnt_q == PW'(FLASH_HALF_CYCLES - 1))) ? '0 : ph_cnt_q + PW'(1);
    phase_d = restart ? 1'b0 : phase_q ^ (ph_cnt_q == PW'(FLASH_HALF_CYCLES - 1));
    code_d = (mon & hit) ? code : (state_d == STARTUP) ? FC_NONE : code_q;
    lane_d = (mon & hit) ? lane : (state_d == STARTUP) ? 2'd0 : lane_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STARTUP;
      filt_q <= '0;
      st_cnt_q <= '0;
      ph_cnt_q <= '0;
      phase_q <= 1'b0;
      code_q <= FC_NONE;
      lane_q <= 2'd0;
    end else begin
      state_q <= state_d;
      filt_q <= filt_d;
      st_cnt_q <= st_cnt_d;
      ph_cnt_q <= ph_cnt_d;
      phase_q <= phase_d;
      code_q <= code_d;
      lane_q <= lane_d;
    end
  end
  assign fault = state_q == FAULT;
  assign flash_enable = state_q != MONITOR;
  assign flash_phase = phase_q;
  assign fault_code = code_q;
  assign fault_lane = lane_q;
`ifdef CM_FAULT_LOG_EN
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (mon & hit & (cnt_q != 8'hff)) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    cnt_q <= !rst_n ? 8'd0 : cnt_d;
  end
  assign fault_count = cnt_q;
`endif
endmodule
